myip_rtc_regs_slave: RTL and testbench
======================================

MYIP_RTC_REGS_SLAVE -- requirements
Module: myip_rtc_regs_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, AXI4-Lite byte-address width; four 32-bit registers.
REQ-003 SHALL have port ACLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port ARESET, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports AWADDR input [3:0], AWPROT input [2:0] (ignored), AWVALID input 1, AWREADY output 1: write address channel.
REQ-006 SHALL have ports WDATA input [31:0], WSTRB input [3:0], WVALID input 1, WREADY output 1: write data channel.
REQ-007 SHALL have ports BRESP output [1:0], BVALID output 1, BREADY input 1: write response channel.
REQ-008 SHALL have ports ARADDR input [3:0], ARPROT input [2:0] (ignored), ARVALID input 1, ARREADY output 1: read address channel.
REQ-009 SHALL have ports RDATA output [31:0], RRESP output [1:0], RVALID output 1, RREADY input 1: read data channel.

Function
REQ-010 SHALL hold four RW registers REG0..REG3 at byte offsets 0x0/0x4/0x8/0xC, selected by ADDR[3:2]; ADDR[1:0] ignored.
REQ-011 Write FSM SHALL have states W_IDLE and W_RESP; read FSM SHALL have states R_IDLE and R_DATA; the two FSMs are independent.
REQ-012 AWREADY SHALL be 1 iff wr_state==W_IDLE and no address is held; WREADY SHALL be 1 iff wr_state==W_IDLE and no data is held; neither depends combinationally on VALID.
REQ-013 AW and W SHALL be captured independently on their own handshake edge, in either order or the same edge; a captured beat is held until the other arrives.
REQ-014 On the edge where both address and data are available (held or handshaking), the write SHALL commit: for each byte b with WSTRB[b]=1, REGn[8b+7:8b] <= data byte b; other bytes unchanged; FSM -> W_RESP; held flags cleared.
REQ-015 In W_RESP, BVALID SHALL be 1 and BRESP SHALL be 2'b00; on the edge with BVALID&&BREADY, FSM -> W_IDLE and BVALID falls next cycle; no new AW/W accepted while in W_RESP.
REQ-016 WSTRB=4'b0000 SHALL leave the register unchanged and still produce one OKAY response.
REQ-017 ARREADY SHALL be 1 iff rd_state==R_IDLE; on ARVALID&&ARREADY, RDATA SHALL be registered from the selected register and FSM -> R_DATA.
REQ-018 In R_DATA, RVALID SHALL be 1, RRESP 2'b00, RDATA stable; on RVALID&&RREADY, FSM -> R_IDLE.
REQ-019 Latency: write commit -> BVALID 1 cycle; AR handshake -> RVALID 1 cycle; back-to-back transactions SHALL sustain one transaction per 2 cycles per direction with READY held high by the master.
REQ-020 Read capture and write commit to the same register on the same edge SHALL return the pre-write value.
REQ-021 Exactly one B beat per committed write and one R beat per AR handshake; no other responses generated.

Reset
REQ-022 While ARESET=1, asynchronously: REG0..REG3=0, both FSMs idle, held flags cleared, BVALID=0, RVALID=0, RDATA=0, BRESP=RRESP=0, AWREADY=WREADY=ARREADY=0.
REQ-023 Asserting ARESET mid-transaction SHALL abort it with no response; after release, READY outputs SHALL be 1 from the first cycle.

Verification
REQ-024 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, read back each -> RDATA 0x1..0x4, all BRESP/RRESP 2'b00.
REQ-025 WVALID (data 0xCAFE0001, strb F) 3 cycles before AWVALID (0x8) -> WREADY low after capture, commit on AW edge, single BVALID, REG2 reads 0xCAFE0001.
REQ-026 BREADY held low 5 cycles after commit -> BVALID stays 1, AWREADY/WREADY stay 0, second write only accepted after B handshake.
REQ-027 REG0=0x11223344, write 0xAABBCCDD with WSTRB=4'b0010 -> REG0 reads 0x1122CC44; WSTRB=0 write -> unchanged, BRESP 00.
REQ-028 REG1=0x5, same-edge write 0x9 to 0x4 and read of 0x4 -> RDATA 0x5; subsequent read -> 0x9.
REQ-029 ARESET pulsed while RVALID=1 and REG3=0x77 -> RVALID 0 immediately, REG3 reads 0 after release, READYs 1 first cycle after release.

Source files
------------

// File: rtl/myip_rtc_regs_slave.sv
// AXI4-Lite slave with four 32-bit read/write registers.
// Independent write (AW/W/B) and read (AR/R) state machines.
module myip_rtc_regs_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                      AWPROT,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                      ARPROT,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int SW       = C_S_AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB = 2;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [0:0]    wr_state_q, wr_state_d;
    logic          aw_held_q, aw_held_d;
    logic          w_held_q, w_held_d;
    logic [1:0]    awsel_q, awsel_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] wstrb_q, wstrb_d;
    logic [DW-1:0] regs_q [4];
    logic [DW-1:0] regs_d [4];

    logic [0:0]    rd_state_q, rd_state_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          wr_idle;
    logic          aw_hs;
    logic          w_hs;
    logic          commit;
    logic [1:0]    wr_sel;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic          ar_hs;
    logic [1:0]    rd_sel;

    // Address LSBs and protection bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{AWPROT, ARPROT,
                         AWADDR[ADDR_LSB-1:0],
                         ARADDR[ADDR_LSB-1:0]};

    assign wr_idle = (wr_state_q == W_IDLE);
    assign AWREADY = wr_idle && !aw_held_q && !ARESET;
    assign WREADY  = wr_idle && !w_held_q && !ARESET;
    assign ARREADY = (rd_state_q == R_IDLE) && !ARESET;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    assign wr_sel  = aw_held_q ? awsel_q
                               : AWADDR[ADDR_LSB+1:ADDR_LSB];
    assign wr_data = w_held_q ? wdata_q : WDATA;
    assign wr_strb = w_held_q ? wstrb_q : WSTRB;
    assign commit  = wr_idle
                  && (aw_held_q || aw_hs)
                  && (w_held_q || w_hs);

    assign rd_sel = ARADDR[ADDR_LSB+1:ADDR_LSB];

    assign BVALID = (wr_state_q == W_RESP);
    assign BRESP  = 2'b00;
    assign RVALID = (rd_state_q == R_DATA);
    assign RRESP  = 2'b00;
    assign RDATA  = rdata_q;

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awsel_d    = awsel_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        unique case (wr_state_q)
            W_IDLE: begin
                if (commit) begin
                    wr_state_d = W_RESP;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                end else begin
                    if (aw_hs) begin
                        aw_held_d = 1'b1;
                        awsel_d   = AWADDR[ADDR_LSB+1:ADDR_LSB];
                    end
                    if (w_hs) begin
                        w_held_d = 1'b1;
                        wdata_d  = WDATA;
                        wstrb_d  = WSTRB;
                    end
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        for (int r = 0; r < 4; r++) begin
            for (int b = 0; b < SW; b++) begin
                if (commit && (wr_sel == 2'(r)) && wr_strb[b]) begin
                    regs_d[r][8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read data is taken from the current register contents, so a
    // same-edge write commit is not visible to this read.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        unique case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = R_DATA;
                    rdata_d    = regs_q[rd_sel];
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state_q <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awsel_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            for (int r = 0; r < 4; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awsel_q    <= awsel_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            for (int r = 0; r < 4; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

endmodule

// File: tb/tb_myip_rtc_regs_slave.sv
// Directed self-checking bench for myip_rtc_regs_slave.
module tb_myip_rtc_regs_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  AWADDR;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  ARADDR;
    logic [2:0]  ARPROT;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    int checks = 0;
    int errors = 0;

    myip_rtc_regs_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWPROT(AWPROT),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB),
        .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    // Bus drivers; entered and left just after a rising edge.
    task automatic do_write(input logic [3:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done = 0;
        bit aw_ok, w_ok, got;
        int n = 0;
        AWADDR = a; WDATA = d; WSTRB = s;
        AWVALID = 1; WVALID = 1; BREADY = 0;
        resp = 2'bxx;
        while (!(aw_done && w_done) && n < 20) begin
            @(negedge ACLK);
            aw_ok = AWVALID && AWREADY;
            w_ok = WVALID && WREADY;
            @(posedge ACLK); #1;
            if (aw_ok) begin AWVALID = 0; aw_done = 1; end
            if (w_ok) begin WVALID = 0; w_done = 1; end
            n++;
        end
        AWVALID = 0; WVALID = 0;
        if (!(aw_done && w_done)) begin
            checks++; errors++;
            $display("FAIL wr_accept_timeout addr=%h got aw=%0b w=%0b need 1 1",
                     a, aw_done, w_done);
        end
        BREADY = 1; n = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge ACLK);
            if (BVALID) begin got = 1; resp = BRESP; end
            @(posedge ACLK); #1;
            n++;
        end
        BREADY = 0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL wr_bresp_timeout addr=%h got no BVALID need BVALID", a);
        end
    endtask

    task automatic do_read(input logic [3:0] a, output logic [31:0] d,
                           output logic [1:0] resp);
        bit done = 0;
        bit ok, got;
        int n = 0;
        ARADDR = a; ARVALID = 1; RREADY = 0;
        d = 'x; resp = 2'bxx;
        while (!done && n < 20) begin
            @(negedge ACLK);
            ok = ARREADY;
            @(posedge ACLK); #1;
            if (ok) begin ARVALID = 0; done = 1; end
            n++;
        end
        ARVALID = 0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL rd_accept_timeout addr=%h got no ARREADY need ARREADY", a);
        end
        RREADY = 1; n = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge ACLK);
            if (RVALID) begin got = 1; d = RDATA; resp = RRESP; end
            @(posedge ACLK); #1;
            n++;
        end
        RREADY = 0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL rd_data_timeout addr=%h got no RVALID need RVALID", a);
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic [1:0]  r;
        ARESET = 1;
        repeat (2) @(posedge ACLK);
        #1;
        checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got aw=%b w=%b ar=%b b=%b r=%b need all 0",
                     AWREADY, WREADY, ARREADY, BVALID, RVALID);
        end
        checks++;
        if (RDATA !== 32'h0 || BRESP !== 2'b00 || RRESP !== 2'b00) begin
            errors++;
            $display("FAIL reset_data got rdata=%h bresp=%b rresp=%b need 0",
                     RDATA, BRESP, RRESP);
        end
        ARESET = 0;
        #1;
        checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready got %b need 111",
                     {AWREADY, WREADY, ARREADY});
        end
        @(posedge ACLK); #1;
        for (int i = 0; i < 4; i++) begin
            do_read(4'(4 * i), d, r);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL reset_reg%0d got %h need 00000000", i, d);
            end
        end
    endtask

    task automatic test_basic;
        logic [31:0] d;
        logic [1:0]  r;
        for (int i = 0; i < 4; i++) begin
            do_write(4'(4 * i), 32'(i + 1), 4'hF, r);
            checks++;
            if (r !== 2'b00) begin
                errors++;
                $display("FAIL basic_bresp%0d got %b need 00", i, r);
            end
        end
        for (int i = 0; i < 4; i++) begin
            do_read(4'(4 * i), d, r);
            checks++;
            if (d !== 32'(i + 1) || r !== 2'b00) begin
                errors++;
                $display("FAIL basic_read%0d got %h/%b need %h/00",
                         i, d, r, 32'(i + 1));
            end
        end
        do_read(4'h7, d, r);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL basic_addr_lsb_ignored got %h need 00000002", d);
        end
    endtask

    task automatic test_w_before_aw;
        logic [31:0] d;
        logic [1:0]  r;
        WDATA = 32'hCAFE0001; WSTRB = 4'hF; WVALID = 1;
        AWVALID = 0; BREADY = 0;
        @(negedge ACLK);
        checks++;
        if (WREADY !== 1'b1) begin
            errors++;
            $display("FAIL wfirst_wready got %b need 1", WREADY);
        end
        @(posedge ACLK); #1;
        WVALID = 0;
        repeat (3) begin
            @(negedge ACLK);
            checks++;
            if (WREADY !== 1'b0 || BVALID !== 1'b0 || AWREADY !== 1'b1) begin
                errors++;
                $display("FAIL wfirst_hold got w=%b b=%b aw=%b need 0 0 1",
                         WREADY, BVALID, AWREADY);
            end
        end
        @(posedge ACLK); #1;
        AWADDR = 4'h8; AWVALID = 1;
        @(negedge ACLK);
        checks++;
        if (AWREADY !== 1'b1) begin
            errors++;
            $display("FAIL wfirst_awready got %b need 1", AWREADY);
        end
        @(posedge ACLK); #1;
        AWVALID = 0;
        checks++;
        if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
            errors++;
            $display("FAIL wfirst_bvalid got %b/%b need 1/00", BVALID, BRESP);
        end
        BREADY = 1;
        @(posedge ACLK); #1;
        BREADY = 0;
        repeat (2) begin
            @(negedge ACLK);
            checks++;
            if (BVALID !== 1'b0) begin
                errors++;
                $display("FAIL wfirst_single_b got %b need 0", BVALID);
            end
        end
        @(posedge ACLK); #1;
        do_read(4'h8, d, r);
        checks++;
        if (d !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL wfirst_reg2 got %h need cafe0001", d);
        end
    endtask

    task automatic test_bready_stall;
        logic [31:0] d;
        logic [1:0]  r;
        AWADDR = 4'h0; WDATA = 32'h11; WSTRB = 4'hF;
        AWVALID = 1; WVALID = 1; BREADY = 0;
        @(negedge ACLK);
        checks++;
        if ({AWREADY, WREADY} !== 2'b11) begin
            errors++;
            $display("FAIL stall_first_ready got %b need 11", {AWREADY, WREADY});
        end
        @(posedge ACLK); #1;
        AWADDR = 4'h4; WDATA = 32'h22;
        repeat (5) begin
            @(negedge ACLK);
            checks++;
            if (BVALID !== 1'b1 || AWREADY !== 1'b0 || WREADY !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold got b=%b aw=%b w=%b need 1 0 0",
                         BVALID, AWREADY, WREADY);
            end
        end
        @(posedge ACLK); #1;
        BREADY = 1;
        @(posedge ACLK); #1;
        BREADY = 0;
        @(negedge ACLK);
        checks++;
        if ({AWREADY, WREADY, BVALID} !== 3'b110) begin
            errors++;
            $display("FAIL stall_reopen got aw/w/b=%b need 110",
                     {AWREADY, WREADY, BVALID});
        end
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 0;
        checks++;
        if (BVALID !== 1'b1) begin
            errors++;
            $display("FAIL stall_second_b got %b need 1", BVALID);
        end
        BREADY = 1;
        @(posedge ACLK); #1;
        BREADY = 0;
        do_read(4'h0, d, r);
        checks++;
        if (d !== 32'h11) begin
            errors++;
            $display("FAIL stall_reg0 got %h need 00000011", d);
        end
        do_read(4'h4, d, r);
        checks++;
        if (d !== 32'h22) begin
            errors++;
            $display("FAIL stall_reg1 got %h need 00000022", d);
        end
    endtask

    task automatic test_strobe;
        logic [31:0] d;
        logic [1:0]  r;
        do_write(4'h0, 32'h11223344, 4'hF, r);
        do_write(4'h0, 32'hAABBCCDD, 4'b0010, r);
        do_read(4'h0, d, r);
        checks++;
        if (d !== 32'h1122CC44) begin
            errors++;
            $display("FAIL strobe_byte1 got %h need 1122cc44", d);
        end
        do_write(4'h0, 32'hFFFFFFFF, 4'b0000, r);
        checks++;
        if (r !== 2'b00) begin
            errors++;
            $display("FAIL strobe_zero_bresp got %b need 00", r);
        end
        do_read(4'h0, d, r);
        checks++;
        if (d !== 32'h1122CC44) begin
            errors++;
            $display("FAIL strobe_zero_keep got %h need 1122cc44", d);
        end
    endtask

    task automatic test_same_edge;
        logic [31:0] d;
        logic [1:0]  r;
        do_write(4'h4, 32'h5, 4'hF, r);
        AWADDR = 4'h4; WDATA = 32'h9; WSTRB = 4'hF;
        AWVALID = 1; WVALID = 1; BREADY = 0;
        ARADDR = 4'h4; ARVALID = 1; RREADY = 0;
        @(negedge ACLK);
        checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            errors++;
            $display("FAIL same_ready got %b need 111",
                     {AWREADY, WREADY, ARREADY});
        end
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        checks++;
        if (RVALID !== 1'b1 || RDATA !== 32'h5 || BVALID !== 1'b1) begin
            errors++;
            $display("FAIL same_old_value got rv=%b rdata=%h bv=%b need 1 00000005 1",
                     RVALID, RDATA, BVALID);
        end
        RREADY = 1; BREADY = 1;
        @(posedge ACLK); #1;
        RREADY = 0; BREADY = 0;
        checks++;
        if (RVALID !== 1'b0 || BVALID !== 1'b0) begin
            errors++;
            $display("FAIL same_close got rv=%b bv=%b need 0 0", RVALID, BVALID);
        end
        do_read(4'h4, d, r);
        checks++;
        if (d !== 32'h9) begin
            errors++;
            $display("FAIL same_new_value got %h need 00000009", d);
        end
    endtask

    task automatic test_back_to_back;
        AWADDR = 4'h0; WDATA = 32'hA0; WSTRB = 4'hF;
        AWVALID = 1; WVALID = 1; BREADY = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            checks++;
            if ({AWREADY, WREADY} !== 2'b11) begin
                errors++;
                $display("FAIL b2b_wr_ready%0d got %b need 11", i, {AWREADY, WREADY});
            end
            @(posedge ACLK); #1;
            if (i < 2) begin
                AWADDR = 4'(4 * (i + 1));
                WDATA = 32'(32'hA0 + i + 1);
            end else begin
                AWVALID = 0; WVALID = 0;
            end
            @(negedge ACLK);
            checks++;
            if (BVALID !== 1'b1) begin
                errors++;
                $display("FAIL b2b_bvalid%0d got %b need 1", i, BVALID);
            end
            @(posedge ACLK); #1;
        end
        BREADY = 0;
        ARADDR = 4'h0; ARVALID = 1; RREADY = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            checks++;
            if (ARREADY !== 1'b1) begin
                errors++;
                $display("FAIL b2b_arready%0d got %b need 1", i, ARREADY);
            end
            @(posedge ACLK); #1;
            if (i < 2) ARADDR = 4'(4 * (i + 1));
            else ARVALID = 0;
            @(negedge ACLK);
            checks++;
            if (RVALID !== 1'b1 || RDATA !== 32'(32'hA0 + i)) begin
                errors++;
                $display("FAIL b2b_rdata%0d got %b/%h need 1/%h",
                         i, RVALID, RDATA, 32'(32'hA0 + i));
            end
            @(posedge ACLK); #1;
        end
        RREADY = 0;
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        logic [1:0]  r;
        do_write(4'hC, 32'h77, 4'hF, r);
        ARADDR = 4'hC; ARVALID = 1; RREADY = 0;
        @(posedge ACLK); #1;
        ARVALID = 0;
        checks++;
        if (RVALID !== 1'b1 || RDATA !== 32'h77) begin
            errors++;
            $display("FAIL rstmid_pre got %b/%h need 1/00000077", RVALID, RDATA);
        end
        #1 ARESET = 1;
        #1;
        checks++;
        if (RVALID !== 1'b0 || RDATA !== 32'h0 || ARREADY !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async got rv=%b rdata=%h ar=%b need 0 0 0",
                     RVALID, RDATA, ARREADY);
        end
        @(posedge ACLK); #1;
        ARESET = 0;
        #1;
        checks++;
        if ({AWREADY, WREADY, ARREADY, RVALID, BVALID} !== 5'b11100) begin
            errors++;
            $display("FAIL rstmid_release got %b need 11100",
                     {AWREADY, WREADY, ARREADY, RVALID, BVALID});
        end
        do_read(4'hC, d, r);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_reg3 got %h need 00000000", d);
        end
    endtask

    initial begin
        ARESET = 1;
        AWADDR = 0; AWPROT = 0; AWVALID = 0;
        WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
        ARADDR = 0; ARPROT = 0; ARVALID = 0; RREADY = 0;
        test_reset();
        test_basic();
        test_w_before_aw();
        test_bready_stall();
        test_strobe();
        test_same_edge();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
